// File: rtl/filtro_comparacion.sv
// -----------------------------------------------------------------------------
// filtro_comparacion
//
// Debounce filter that sits after the sequential 8-bit comparator. It takes
// the comparator's registered flags q (A>B) and q_lt (A<B) and turns them
// into a stable relation state (EQ/GT/LT). A new relation is only accepted
// once it has been seen on N_ESTABLE consecutive qualified samples, where a
// qualified sample is any cycle with en=1.
//
// Parameters:
//   N_ESTABLE  consecutive qualified samples needed to switch estado (1..255)
//   CW         width of the saturating change counter cnt_cambios
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active low, highest priority
//   en           sample qualifier; q/q_lt are ignored while en=0
//   q            comparator flag A>B
//   q_lt         comparator flag A<B
//   estado       filtered relation: 2'b00 EQ, 2'b01 GT, 2'b10 LT
//   cambio       one-cycle pulse, high in the cycle estado shows a new value
//   cnt_cambios  accepted relation changes, saturating at all-ones
//   err          one-cycle pulse per qualified sample with q=1 and q_lt=1
//   err_sticky   (only with FILTRO_ERR_STICKY_EN defined) latched err,
//                cleared only by rst_n
//
// Build option:
//   FILTRO_ERR_STICKY_EN  when defined, adds the err_sticky output and its
//                         register. The default build leaves it out.
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module filtro_comparacion #(
    parameter int N_ESTABLE = 4,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          q,
    input  logic          q_lt,
    output logic [1:0]    estado,
    output logic          cambio,
    output logic [CW-1:0] cnt_cambios,
    output logic          err
`ifdef FILTRO_ERR_STICKY_EN
    ,
    output logic          err_sticky
`endif
);

    // Run counter only has to reach N_ESTABLE, so this width never wraps.
    localparam int RW = $clog2(N_ESTABLE + 1);

    localparam logic [RW-1:0] RUN_TARGET = RW'(N_ESTABLE);
    localparam logic [RW-1:0] RUN_ONE    = RW'(1);
    localparam logic [RW-1:0] RUN_ZERO   = '0;
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    // Encoding doubles as the estado output code; ILLEGAL is never stored
    // in estado_r.
    typedef enum logic [1:0] {
        REL_EQ  = 2'b00,
        REL_GT  = 2'b01,
        REL_LT  = 2'b10,
        REL_ILL = 2'b11
    } rel_e;

    // Map the two comparator flags onto a relation.
    function automatic rel_e classify(input logic gt_flag, input logic lt_flag);
        rel_e rel;
        case ({gt_flag, lt_flag})
            2'b10:   rel = REL_GT;
            2'b01:   rel = REL_LT;
            2'b00:   rel = REL_EQ;
            default: rel = REL_ILL;
        endcase
        return rel;
    endfunction

    rel_e          estado_r;
    rel_e          cand_r;
    logic [RW-1:0] run_r;
    logic          cambio_r;
    logic [CW-1:0] cnt_r;
    logic          err_r;

    rel_e          raw_s;
    rel_e          estado_nx_s;
    rel_e          cand_nx_s;
    logic [RW-1:0] run_nx_s;
    logic [RW-1:0] run_step_s;
    logic          cambio_nx_s;
    logic [CW-1:0] cnt_nx_s;
    logic          err_nx_s;

    // Classify the current comparator sample.
    always_comb begin
        raw_s = classify(q, q_lt);
    end

    // Next-state logic for the debounce run, relation state and pulses.
    always_comb begin
        estado_nx_s = estado_r;
        cand_nx_s   = cand_r;
        run_nx_s    = run_r;
        run_step_s  = RUN_ZERO;
        cambio_nx_s = 1'b0;
        cnt_nx_s    = cnt_r;
        err_nx_s    = 1'b0;

        if (en) begin
            if (raw_s == REL_ILL) begin
                // Bad sample: flag it and force the run to start over.
                err_nx_s = 1'b1;
                run_nx_s = RUN_ZERO;
            end else if (raw_s == estado_r) begin
                // Current relation confirmed again; any pending run is broken.
                run_nx_s = RUN_ZERO;
            end else begin
                // A different relation restarts the count at one; the same
                // candidate extends it. After a clear (err or estado match)
                // run_r is 0, so extending also yields one.
                if (raw_s != cand_r) begin
                    run_step_s = RUN_ONE;
                end else begin
                    run_step_s = run_r + RUN_ONE;
                end

                cand_nx_s = raw_s;

                if (run_step_s == RUN_TARGET) begin
                    estado_nx_s = raw_s;
                    run_nx_s    = RUN_ZERO;
                    cambio_nx_s = 1'b1;
                    if (cnt_r == CNT_MAX) begin
                        cnt_nx_s = cnt_r;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    run_nx_s = run_step_s;
                end
            end
        end else begin
            // No sample this cycle: run and candidate hold, pulses drop.
            run_nx_s  = run_r;
            cand_nx_s = cand_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_r <= REL_EQ;
            cand_r   <= REL_EQ;
            run_r    <= RUN_ZERO;
            cambio_r <= 1'b0;
            cnt_r    <= '0;
            err_r    <= 1'b0;
        end else begin
            estado_r <= estado_nx_s;
            cand_r   <= cand_nx_s;
            run_r    <= run_nx_s;
            cambio_r <= cambio_nx_s;
            cnt_r    <= cnt_nx_s;
            err_r    <= err_nx_s;
        end
    end

    assign estado      = estado_r;
    assign cambio      = cambio_r;
    assign cnt_cambios = cnt_r;
    assign err         = err_r;

`ifdef FILTRO_ERR_STICKY_EN
    logic err_sticky_r;

    // Latch any err pulse on the same edge the pulse is registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky_r <= 1'b0;
        end else begin
            err_sticky_r <= err_sticky_r | err_nx_s;
        end
    end

    assign err_sticky = err_sticky_r;
`endif

endmodule

// File: tb/tb_filtro_comparacion.sv
module tb_filtro_comparacion;

    logic clk;
    logic rst_n;
    logic en;
    logic q;
    logic q_lt;

    logic [1:0] estado,  estado_s2,  estado_n1;
    logic       cambio,  cambio_s2,  cambio_n1;
    logic [7:0] cnt,                 cnt_n1;
    logic [1:0]          cnt_s2;
    logic       err,     err_s2,     err_n1;
`ifdef FILTRO_ERR_STICKY_EN
    logic       sticky,  sticky_s2,  sticky_n1;
`endif

    int pass_cnt;
    int total_cnt;

    filtro_comparacion #(.N_ESTABLE(4), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .q(q), .q_lt(q_lt),
        .estado(estado), .cambio(cambio), .cnt_cambios(cnt), .err(err)
`ifdef FILTRO_ERR_STICKY_EN
        , .err_sticky(sticky)
`endif
    );

    filtro_comparacion #(.N_ESTABLE(4), .CW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .q(q), .q_lt(q_lt),
        .estado(estado_s2), .cambio(cambio_s2), .cnt_cambios(cnt_s2), .err(err_s2)
`ifdef FILTRO_ERR_STICKY_EN
        , .err_sticky(sticky_s2)
`endif
    );

    filtro_comparacion #(.N_ESTABLE(1), .CW(8)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .en(en), .q(q), .q_lt(q_lt),
        .estado(estado_n1), .cambio(cambio_n1), .cnt_cambios(cnt_n1), .err(err_n1)
`ifdef FILTRO_ERR_STICKY_EN
        , .err_sticky(sticky_n1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; en = 1'b0; q = 1'b0; q_lt = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; q = 1'b1; q_lt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (estado !== 2'b00 || cambio !== 1'b0 || cnt !== 8'd0 || err !== 1'b0)
                $display("FAIL reset_hold cyc=%0d got est=%b cb=%b cnt=%0d err=%b exp 00/0/0/0",
                         i, estado, cambio, cnt, err);
            else pass_cnt++;
        end
`ifdef FILTRO_ERR_STICKY_EN
        total_cnt++;
        if (sticky !== 1'b0) $display("FAIL reset_sticky got=%b exp=0", sticky);
        else pass_cnt++;
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (estado !== 2'b00 || cambio !== 1'b0)
                $display("FAIL reset_release cyc=%0d got est=%b cb=%b exp 00/0", i, estado, cambio);
            else pass_cnt++;
        end
    endtask

    task automatic test_debounce();
        apply_reset();
        en = 1'b1; q = 1'b1; q_lt = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total_cnt++;
            if (i < 4) begin
                if (estado !== 2'b00 || cambio !== 1'b0)
                    $display("FAIL deb_wait s=%0d got est=%b cb=%b exp 00/0", i, estado, cambio);
                else pass_cnt++;
            end else begin
                if (estado !== 2'b01 || cambio !== 1'b1 || cnt !== 8'd1)
                    $display("FAIL deb_switch got est=%b cb=%b cnt=%0d exp 01/1/1", estado, cambio, cnt);
                else pass_cnt++;
            end
        end
        tick();
        total_cnt++;
        if (estado !== 2'b01 || cambio !== 1'b0 || cnt !== 8'd1)
            $display("FAIL deb_after got est=%b cb=%b cnt=%0d exp 01/0/1", estado, cambio, cnt);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        apply_reset();
        en = 1'b1; q_lt = 1'b0;
        for (int i = 0; i < 7; i++) begin
            q = (i == 3) ? 1'b0 : 1'b1;
            tick();
            total_cnt++;
            if (estado !== 2'b00 || cambio !== 1'b0 || cnt !== 8'd0)
                $display("FAIL glitch s=%0d got est=%b cb=%b cnt=%0d exp 00/0/0", i, estado, cambio, cnt);
            else pass_cnt++;
        end
        q = 1'b1;
        tick();
        total_cnt++;
        if (estado !== 2'b01 || cambio !== 1'b1)
            $display("FAIL glitch_4th got est=%b cb=%b exp 01/1", estado, cambio);
        else pass_cnt++;
    endtask

    task automatic test_en_gating();
        logic ens [7];
        ens = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        apply_reset();
        q = 1'b1; q_lt = 1'b0;
        for (int i = 0; i < 7; i++) begin
            en = ens[i];
            tick();
            total_cnt++;
            if (estado !== ((i == 6) ? 2'b01 : 2'b00) || cambio !== (i == 6))
                $display("FAIL en_gate s=%0d got est=%b cb=%b exp %b/%b",
                         i, estado, cambio, (i == 6) ? 2'b01 : 2'b00, (i == 6));
            else pass_cnt++;
        end
        en = 1'b0;
        tick();
        total_cnt++;
        if (estado !== 2'b01 || cambio !== 1'b0)
            $display("FAIL en_idle got est=%b cb=%b exp 01/0", estado, cambio);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        apply_reset();
        en = 1'b1; q = 1'b1; q_lt = 1'b0;
        tick(); tick();
        q_lt = 1'b1;
        tick();
        total_cnt++;
        if (err !== 1'b1 || estado !== 2'b00 || cambio !== 1'b0)
            $display("FAIL ill_pulse got err=%b est=%b cb=%b exp 1/00/0", err, estado, cambio);
        else pass_cnt++;
`ifdef FILTRO_ERR_STICKY_EN
        total_cnt++;
        if (sticky !== 1'b1) $display("FAIL ill_sticky got=%b exp=1", sticky);
        else pass_cnt++;
`endif
        // Illegal flags with en=0 are not a sample.
        en = 1'b0;
        tick();
        total_cnt++;
        if (err !== 1'b0) $display("FAIL ill_en0 got err=%b exp=0", err);
        else pass_cnt++;
        en = 1'b1; q_lt = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total_cnt++;
            if (err !== 1'b0 || estado !== ((i == 4) ? 2'b01 : 2'b00))
                $display("FAIL ill_restart s=%0d got err=%b est=%b exp 0/%b",
                         i, err, estado, (i == 4) ? 2'b01 : 2'b00);
            else pass_cnt++;
        end
`ifdef FILTRO_ERR_STICKY_EN
        total_cnt++;
        if (sticky !== 1'b1) $display("FAIL ill_sticky_hold got=%b exp=1", sticky);
        else pass_cnt++;
`endif
    endtask

    task automatic test_saturation();
        logic [1:0] rel;
        logic [1:0] exp_s2;
        apply_reset();
        en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rel = (c % 2 == 0) ? 2'b01 : 2'b10;
            q = rel[0]; q_lt = rel[1];
            tick(); tick(); tick();
            total_cnt++;
            if (cambio !== 1'b0) $display("FAIL sat_early c=%0d got cb=%b exp 0", c, cambio);
            else pass_cnt++;
            tick();
            exp_s2 = (c >= 2) ? 2'd3 : 2'(c + 1);
            total_cnt++;
            if (estado !== rel || cambio !== 1'b1 || cnt !== 8'(c + 1) ||
                estado_s2 !== rel || cnt_s2 !== exp_s2)
                $display("FAIL sat_chg c=%0d got est=%b cb=%b cnt=%0d cnt2=%0d exp %b/1/%0d/%0d",
                         c, estado, cambio, cnt, cnt_s2, rel, c + 1, exp_s2);
            else pass_cnt++;
        end
        // Partial LT run, then reset wins.
        q = 1'b0; q_lt = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        total_cnt++;
        if (estado !== 2'b00 || cnt !== 8'd0 || estado_s2 !== 2'b00 || cnt_s2 !== 2'd0 || cambio !== 1'b0)
            $display("FAIL sat_midrst got est=%b cnt=%0d est2=%b cnt2=%0d cb=%b exp 00/0/00/0/0",
                     estado, cnt, estado_s2, cnt_s2, cambio);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_n1_back_to_back();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b10, 2'b01, 2'b00};
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q = seq[i][0]; q_lt = seq[i][1];
            tick();
            total_cnt++;
            if (estado_n1 !== seq[i] || cambio_n1 !== 1'b1 || cnt_n1 !== 8'(i + 1))
                $display("FAIL n1_alt s=%0d got est=%b cb=%b cnt=%0d exp %b/1/%0d",
                         i, estado_n1, cambio_n1, cnt_n1, seq[i], i + 1);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (estado_n1 !== 2'b00 || cambio_n1 !== 1'b0)
            $display("FAIL n1_hold got est=%b cb=%b exp 00/0", estado_n1, cambio_n1);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst_n = 1'b0; en = 1'b0; q = 1'b0; q_lt = 1'b0;
        test_reset();
        test_debounce();
        test_glitch();
        test_en_gating();
        test_illegal();
        test_saturation();
        test_n1_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
